// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// master = sequencer side, slave = datapath side.
interface mc_ctrl_fsm_if;
  logic [5:0] opcode;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] mem_size;
  logic       ir_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       instr_done;
  logic       illegal_op;
  logic       bus_err;
  logic [3:0] state;

  modport master (
    input  opcode, rt, rd, mem_ready,
    output pc_write, pc_write_cond, pc_source, iord,
    output mem_read, mem_write, mem_size, ir_write,
    output alu_src_a, alu_src_b, alu_op, reg_dst,
    output mem_to_reg, reg_write, instr_done,
    output illegal_op, bus_err, state
  );

  modport slave (
    output opcode, rt, rd, mem_ready,
    input  pc_write, pc_write_cond, pc_source, iord,
    input  mem_read, mem_write, mem_size, ir_write,
    input  alu_src_a, alu_src_b, alu_op, reg_dst,
    input  mem_to_reg, reg_write, instr_done,
    input  illegal_op, bus_err, state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// memory-ready handshake and per-access timeout.
module mc_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic          clk,
  input  logic          rst,
  mc_ctrl_fsm_if.master bus
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_e;

  localparam bit               TMO_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CMAX   = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       wait_st, rdy, tmo;
  logic       is_r, is_j, is_beq, is_addi;
  logic       is_ld, is_st;
  logic [1:0] size;

  assign wait_st = (state_q == FETCH) ||
                   (state_q == MEMRD) ||
                   (state_q == MEMWR);
  assign rdy = wait_st && bus.mem_ready;
  // ready on the timeout cycle takes priority
  assign tmo = TMO_EN && wait_st &&
               !bus.mem_ready && (cnt_q == TMO);

  always_comb begin
    is_r    = 1'b0;
    is_j    = 1'b0;
    is_beq  = 1'b0;
    is_addi = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    unique case (1'b1)
      bus.opcode == 6'b000000: is_r = 1'b1;
      bus.opcode == 6'b000010: is_j = 1'b1;
      bus.opcode == 6'b000100: is_beq = 1'b1;
      bus.opcode == 6'b001000: is_addi = 1'b1;
      bus.opcode inside {6'b100011, 6'b100001, 6'b100000}:
        is_ld = 1'b1;
      bus.opcode inside {6'b101011, 6'b101001, 6'b101000}:
        is_st = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    unique case (bus.opcode[1:0])
      2'b01:   size = 2'b01;
      2'b00:   size = 2'b10;
      default: size = 2'b00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:  if (rdy) state_d = DECODE;
              else if (tmo) state_d = FETCH;
      DECODE: begin
        unique case (1'b1)
          is_r:           state_d = EXEC;
          is_j:           state_d = JUMP;
          is_beq:         state_d = BRANCH;
          is_addi:        state_d = ADDIEX;
          is_ld || is_st: state_d = MEMADR;
          default:        state_d = FETCH;
        endcase
      end
      MEMADR: state_d = bus.opcode[3] ? MEMWR : MEMRD;
      MEMRD:  if (rdy) state_d = MEMWB;
              else if (tmo) state_d = FETCH;
      MEMWR:  if (rdy || tmo) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      MEMWB, ALUWB, BRANCH, JUMP, ADDIWB:
              state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (wait_st && !bus.mem_ready && !tmo)
      cnt_d = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_source     = 2'b00;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_size      = 2'b00;
    bus.ir_write      = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.instr_done    = 1'b0;
    bus.illegal_op    = 1'b0;
    bus.bus_err       = 1'b0;
    bus.state         = 4'd0;
    if (!rst) begin
      bus.state   = state_q;
      bus.bus_err = tmo;
      unique case (state_q)
        FETCH: begin
          bus.mem_read  = !tmo;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = rdy;
          bus.pc_write  = rdy;
        end
        DECODE: begin
          bus.alu_src_b  = 2'b11;
          bus.illegal_op = !(is_r || is_j || is_beq ||
                             is_addi || is_ld || is_st);
        end
        MEMADR, ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        MEMRD: begin
          bus.mem_read = !tmo;
          bus.iord     = 1'b1;
          bus.mem_size = size;
        end
        MEMWB: begin
          bus.mem_to_reg = 1'b1;
          bus.reg_write  = (bus.rt != 5'd0);
          bus.instr_done = 1'b1;
        end
        MEMWR: begin
          bus.mem_write  = !tmo;
          bus.iord       = 1'b1;
          bus.mem_size   = size;
          bus.instr_done = rdy;
        end
        EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
        end
        ALUWB: begin
          bus.reg_dst    = 1'b1;
          bus.reg_write  = (bus.rd != 5'd0);
          bus.instr_done = 1'b1;
        end
        BRANCH: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = 2'b01;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = 2'b01;
          bus.instr_done    = 1'b1;
        end
        JUMP: begin
          bus.pc_write   = 1'b1;
          bus.pc_source  = 2'b10;
          bus.instr_done = 1'b1;
        end
        ADDIWB: begin
          bus.reg_write  = (bus.rt != 5'd0);
          bus.instr_done = 1'b1;
        end
        default: bus.state = 4'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed cases then random instruction stream,
// checked cycle by cycle against an instruction-level reference.
module tb_mc_ctrl_fsm;
  localparam int TMO = 4;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcs;
    logic       iord;
    logic       mr;
    logic       mw;
    logic [1:0] msz;
    logic       irw;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] op;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       done;
    logic       ill;
    logic       berr;
    logic [3:0] st;
  } ov_t;

  localparam logic [5:0] LD_OP [3] = '{6'h23, 6'h21, 6'h20};
  localparam logic [5:0] ST_OP [3] = '{6'h2b, 6'h29, 6'h28};
  localparam logic [1:0] SZ    [3] = '{2'b00, 2'b01, 2'b10};

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    n_vec = 0;
  int    n_err = 0;
  string tag = "reset";

  mc_ctrl_fsm_if bus ();

  mc_ctrl_fsm #(
    .MEM_TIMEOUT(TMO),
    .CNT_W      (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic ov_t obs();
    ov_t o;
    o.pcw  = bus.pc_write;
    o.pcwc = bus.pc_write_cond;
    o.pcs  = bus.pc_source;
    o.iord = bus.iord;
    o.mr   = bus.mem_read;
    o.mw   = bus.mem_write;
    o.msz  = bus.mem_size;
    o.irw  = bus.ir_write;
    o.sa   = bus.alu_src_a;
    o.sb   = bus.alu_src_b;
    o.op   = bus.alu_op;
    o.rdst = bus.reg_dst;
    o.m2r  = bus.mem_to_reg;
    o.rw   = bus.reg_write;
    o.done = bus.instr_done;
    o.ill  = bus.illegal_op;
    o.berr = bus.bus_err;
    o.st   = bus.state;
    return o;
  endfunction

  function automatic ov_t v(input int st);
    ov_t e;
    e = '0;
    e.st = 4'(st);
    return e;
  endfunction

  function automatic ov_t fetch_v(input bit rdy);
    ov_t e;
    e = v(0);
    e.mr = 1'b1;
    e.sb = 2'b01;
    e.irw = rdy;
    e.pcw = rdy;
    return e;
  endfunction

  function automatic bit legal(input logic [5:0] o);
    return o inside {6'h00, 6'h02, 6'h04, 6'h08,
                     6'h23, 6'h21, 6'h20,
                     6'h2b, 6'h29, 6'h28};
  endfunction

  task automatic cyc(input logic rdy, input ov_t e);
    ov_t o;
    bus.mem_ready = rdy;
    @(negedge clk);
    o = obs();
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
    @(posedge clk);
    #1;
  endtask

  // non-wait states must ignore mem_ready
  task automatic step(input ov_t e);
    cyc(1'($urandom_range(0, 1)), e);
  endtask

  // one memory access with w not-ready cycles before ready
  task automatic access(input ov_t base, input ov_t fin,
                        input int w, output bit ok);
    ov_t e;
    bit  fin_d;
    ok = 1'b0;
    fin_d = 1'b0;
    for (int k = 0; k <= TMO && !fin_d; k++) begin
      if (k >= w) begin
        cyc(1'b1, fin);
        ok = 1'b1;
        fin_d = 1'b1;
      end else begin
        e = base;
        if (k == TMO) begin
          e.mr = 1'b0;
          e.mw = 1'b0;
          e.berr = 1'b1;
        end
        cyc(1'b0, e);
      end
    end
  endtask

  function automatic int rw_t();
    return int'($urandom_range(0, TMO + 2));
  endfunction

  task automatic do_instr(input logic [5:0] op, input logic [4:0] rt_v,
                          input logic [4:0] rd_v, input int fw,
                          input int mwt);
    ov_t e, f;
    bit ok;
    int ld, sd;
    bus.opcode = op;
    bus.rt = rt_v;
    bus.rd = rd_v;
    access(fetch_v(1'b0), fetch_v(1'b1), fw, ok);
    if (!ok) access(fetch_v(1'b0), fetch_v(1'b1),
                    int'($urandom_range(0, TMO)), ok);
    ld = -1;
    sd = -1;
    for (int i = 0; i < 3; i++) begin
      if (op == LD_OP[i]) ld = i;
      if (op == ST_OP[i]) sd = i;
    end
    e = v(1);
    e.sb = 2'b11;
    e.ill = !legal(op);
    step(e);
    if (op == 6'h00) begin
      e = v(6); e.sa = 1'b1; e.op = 2'b10; step(e);
      e = v(7); e.rdst = 1'b1; e.rw = (rd_v != 0); e.done = 1'b1;
      step(e);
    end else if (op == 6'h02) begin
      e = v(9); e.pcw = 1'b1; e.pcs = 2'b10; e.done = 1'b1; step(e);
    end else if (op == 6'h04) begin
      e = v(8); e.sa = 1'b1; e.op = 2'b01; e.pcwc = 1'b1;
      e.pcs = 2'b01; e.done = 1'b1; step(e);
    end else if (op == 6'h08) begin
      e = v(10); e.sa = 1'b1; e.sb = 2'b10; step(e);
      e = v(11); e.rw = (rt_v != 0); e.done = 1'b1; step(e);
    end else if (ld >= 0 || sd >= 0) begin
      e = v(2); e.sa = 1'b1; e.sb = 2'b10; step(e);
      f = v(ld >= 0 ? 3 : 5);
      f.iord = 1'b1;
      f.msz = SZ[ld >= 0 ? ld : sd];
      f.mr = (ld >= 0);
      f.mw = (sd >= 0);
      e = f;
      e.done = (sd >= 0);
      access(f, e, mwt, ok);
      if (ok && ld >= 0) begin
        e = v(4); e.m2r = 1'b1; e.rw = (rt_v != 0); e.done = 1'b1;
        step(e);
      end
    end
  endtask

  initial begin
    logic [5:0] op;
    logic [4:0] a, b;
    int cls;
    bus.opcode = 6'h00;
    bus.rt = 5'd0;
    bus.rd = 5'd0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc(1'b1, '0);
    rst = 1'b0;

    tag = "rtype_rd5";   do_instr(6'h00, 5'd7, 5'd5, 0, 0);
    tag = "lh_wait2";    do_instr(6'h21, 5'd3, 5'd9, 0, 2);
    tag = "addi_rt0";    do_instr(6'h08, 5'd0, 5'd4, 0, 0);
    tag = "fetch_tmo";   do_instr(6'h00, 5'd1, 5'd2, TMO + 1, 0);
    tag = "illegal_3f";  do_instr(6'h3f, 5'd6, 5'd6, 0, 0);
    tag = "lw_rdy_tmo";  do_instr(6'h23, 5'd2, 5'd0, TMO, TMO);
    tag = "sb_tmo";      do_instr(6'h28, 5'd1, 5'd1, 0, TMO + 2);
    tag = "rtype_rd0";   do_instr(6'h00, 5'd3, 5'd0, 1, 0);
    tag = "beq";         do_instr(6'h04, 5'd3, 5'd4, 0, 0);
    tag = "jump";        do_instr(6'h02, 5'd3, 5'd4, 2, 0);

    tag = "mid_reset";
    bus.opcode = 6'h00;
    cyc(1'b1, fetch_v(1'b1));
    begin
      ov_t e;
      e = v(1);
      e.sb = 2'b11;
      cyc(1'b1, e);
    end
    rst = 1'b1;
    cyc(1'b1, '0);
    rst = 1'b0;
    tag = "after_reset"; do_instr(6'h2b, 5'd8, 5'd1, 0, 1);

    tag = "random";
    for (int n = 0; n < 200; n++) begin
      cls = int'($urandom_range(0, 6));
      a = 5'($urandom);
      b = 5'($urandom);
      if ($urandom_range(0, 3) == 0) a = 5'd0;
      if ($urandom_range(0, 3) == 0) b = 5'd0;
      case (cls)
        0: op = 6'h00;
        1: op = 6'h02;
        2: op = 6'h04;
        3: op = 6'h08;
        4: op = LD_OP[$urandom_range(0, 2)];
        5: op = ST_OP[$urandom_range(0, 2)];
        default: begin
          op = 6'($urandom);
          for (int t = 0; t < 64 && legal(op); t++) op = op + 6'd1;
        end
      endcase
      do_instr(op, a, b, rw_t(), rw_t());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
